// File: rtl/wb_master_engine.sv
// -----------------------------------------------------------------------------
// wb_master_engine
//   Wishbone B3 classic master. A local requester pushes read/write beats into
//   a command FIFO; each beat becomes one Wishbone transfer. Beats are chained
//   inside a single CYC_O cycle until a beat flagged last. RTY_I is retried a
//   bounded number of times. A silent slave is aborted after TIMEOUT strobe
//   cycles. After a failed beat, the rest of its cycle is flushed from the
//   FIFO. One response per issued beat is presented on a valid/ready port.
//
// Ports
//   CLK_I, RST_I          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command push handshake (cmd_ready = FIFO not full)
//   cmd_we/adr/dat/sel    beat direction, address, write data, byte selects
//   cmd_last              final beat of the Wishbone cycle
//   rsp_valid/rsp_ready   response handshake
//   rsp_dat/rsp_err       read data (0 for writes), beat failed
//   busy                  FIFO non-empty or CYC_O high
//   ADR_O..WE_O           Wishbone master outputs
//   DAT_I, ACK_I, ERR_I, RTY_I  Wishbone slave returns
// -----------------------------------------------------------------------------
module wb_master_engine #(
  parameter int AW        = 32,
  parameter int DW        = 32,   // multiple of 8
  parameter int DEPTH     = 4,    // power of two, >= 2
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255   // 0 disables the bus timeout
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic            cmd_last,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            busy,
  output logic [AW-1:0]   ADR_O,
  output logic [DW-1:0]   DAT_O,
  output logic [DW/8-1:0] SEL_O,
  output logic            CYC_O,
  output logic            STB_O,
  output logic            WE_O,
  input  logic [DW-1:0]   DAT_I,
  input  logic            ACK_I,
  input  logic            ERR_I,
  input  logic            RTY_I
);

  localparam int SW = DW / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          last;
  } beat_t;

  typedef enum logic [2:0] {IDLE, XFER, HOLD, BACKOFF, FLUSH} state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  beat_t         mem [DEPTH];
  beat_t         in_beat;
  beat_t         head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          empty;

  state_t        state;

  assign in_beat   = {cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_last};
  assign head      = mem[rd_ptr];
  assign empty     = (count == '0);
  // Ready is a registered not-full flag, masked so it reads 0 while in reset.
  assign cmd_ready = ready_q && !RST_I;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !empty || CYC_O;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE, HOLD: pop = !empty && !rsp_valid;
      FLUSH:      pop = !empty;
      default:    pop = 1'b0;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // NOTE: the storage array has no reset; validity is carried by the pointers and count alone.
  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      ready_q <= (count_nxt != (PW+1)'(DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus sequencer
  // ---------------------------------------------------------------------------
  logic          cur_last;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic          retry_ok;
  logic          timeout_hit;
  logic          fail_now;

  assign retry_ok    = (rcnt < RW'(MAX_RETRY));
  // tcnt counts strobe cycles already elapsed; this edge closes cycle TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  // ERR, exhausted retries and timeout all end the beat the same way.
  assign fail_now    = ERR_I || (RTY_I && !retry_ok) || (!RTY_I && !ACK_I && timeout_hit);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= IDLE;
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      cur_last  <= 1'b0;
      rcnt      <= '0;
      tcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      unique case (state)
        IDLE, HOLD: begin
          if (pop) begin
            ADR_O    <= head.adr;
            DAT_O    <= head.dat;
            SEL_O    <= head.sel;
            WE_O     <= head.we;
            cur_last <= head.last;
            CYC_O    <= 1'b1;
            STB_O    <= 1'b1;
            rcnt     <= '0;
            tcnt     <= '0;
            state    <= XFER;
          end
        end

        XFER: begin
          if (fail_now) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= '0;
            rcnt      <= '0;
            state     <= cur_last ? IDLE : FLUSH;
          end else if (RTY_I) begin
            CYC_O <= 1'b0;
            STB_O <= 1'b0;
            rcnt  <= rcnt + 1'b1;
            state <= BACKOFF;
          end else if (ACK_I) begin
            STB_O     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dat   <= WE_O ? '0 : DAT_I;
            rcnt      <= '0;
            if (cur_last) begin
              CYC_O <= 1'b0;
              state <= IDLE;
            end else begin
              state <= HOLD;
            end
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end

        // One dead cycle, then the latched beat goes out again unchanged.
        BACKOFF: begin
          CYC_O <= 1'b1;
          STB_O <= 1'b1;
          tcnt  <= '0;
          state <= XFER;
        end

        // Discard the remainder of a failed cycle, up to and including its last beat.
        FLUSH: begin
          if (pop && head.last) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_engine.sv
// -----------------------------------------------------------------------------
// tb_wb_master_engine
//   Self-checking bench for wb_master_engine (MAX_RETRY=3, TIMEOUT=8, DEPTH=4).
//   Each pushed command carries a slave script (RTY count, final termination,
//   wait states). A reference model evaluates the script at push time and
//   queues the expected bus attempts and the expected response. A scripted
//   slave checks each attempt against the attempt queue, and a response
//   monitor checks each response against the response queue.
// -----------------------------------------------------------------------------
module tb_wb_master_engine;

  localparam int MAXR  = 3;
  localparam int TMO   = 8;
  localparam int T_ACK = 0;
  localparam int T_ERR = 1;
  localparam int T_SIL = 2;
  localparam int T_RTY = 3;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_last;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        CYC_O, STB_O, WE_O, ACK_I, ERR_I, RTY_I;

  wb_master_engine #(
    .AW(32), .DW(32), .DEPTH(4), .MAX_RETRY(MAXR), .TIMEOUT(TMO)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .busy(busy),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .CYC_O(CYC_O),
    .STB_O(STB_O), .WE_O(WE_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
  );

  initial forever #5 CLK_I = ~CLK_I;

  typedef struct {
    bit        we;
    bit [31:0] adr;
    bit [31:0] dat;
    bit [3:0]  sel;
    bit        last;
    int        nrty;
    int        term;
    int        waits;
  } cmd_t;

  typedef struct {
    bit        we;
    bit [31:0] adr;
    bit [31:0] dat;
    bit [3:0]  sel;
    int        term;
    int        waits;
  } att_t;

  typedef struct {
    bit        err;
    bit [31:0] dat;
  } rsp_t;

  att_t      att_q[$];
  rsp_t      rsp_q[$];
  bit [31:0] model_mem[16];
  bit [31:0] slave_mem[16];
  bit        flushing;
  int        checks;
  int        errors;
  int        cyc_falls;
  int        ready_hold;
  bit        rand_ready;
  int        max_hold_len;
  bit        slave_reset;
  bit        mon_reset;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] sel);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic cmd_t mk(input bit we, input bit [31:0] adr, input bit [31:0] dat,
                              input bit [3:0] sel, input bit last, input int nrty,
                              input int term, input int waits);
    cmd_t c;
    c.we = we; c.adr = adr; c.dat = dat; c.sel = sel; c.last = last;
    c.nrty = nrty; c.term = term; c.waits = waits;
    return c;
  endfunction

  // Reference model: what the bus and the response port must show for one beat.
  function automatic void model_accept(input cmd_t c);
    att_t a;
    rsp_t r;
    bit   exhausted;
    if (flushing) begin
      if (c.last) flushing = 1'b0;
      return;
    end
    a.we = c.we; a.adr = c.adr; a.dat = c.dat; a.sel = c.sel; a.waits = c.waits;
    exhausted = (c.nrty > MAXR);
    for (int i = 0; i < ((c.nrty < MAXR + 1) ? c.nrty : MAXR + 1); i++) begin
      a.term = T_RTY;
      att_q.push_back(a);
    end
    if (!exhausted) begin
      a.term = c.term;
      att_q.push_back(a);
    end
    r.err = exhausted || (c.term != T_ACK);
    r.dat = '0;
    if (!r.err) begin
      if (c.we) model_mem[c.adr[5:2]] = merge(model_mem[c.adr[5:2]], c.dat, c.sel);
      else      r.dat = model_mem[c.adr[5:2]];
    end
    rsp_q.push_back(r);
    if (r.err && !c.last) flushing = 1'b1;
  endfunction

  task automatic push(input cmd_t c);
    int n = 0;
    @(negedge CLK_I);
    cmd_valid = 1'b1;
    cmd_we = c.we; cmd_adr = c.adr; cmd_dat = c.dat; cmd_sel = c.sel; cmd_last = c.last;
    while (!cmd_ready && n < 500) begin
      @(negedge CLK_I);
      n++;
    end
    if (n >= 500) check("push_ready_timeout", cmd_ready, 1);
    model_accept(c);
    @(posedge CLK_I);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || rsp_valid || rsp_q.size() != 0 || att_q.size() != 0) && n < 3000) begin
      @(negedge CLK_I);
      n++;
    end
    check({"idle_", tag}, {busy, rsp_valid, rsp_q.size() != 0, att_q.size() != 0}, 0);
    repeat (2) @(negedge CLK_I);
  endtask

  // Scripted slave: consumes one expected attempt per strobe.
  initial begin : slave
    att_t a;
    bit   active = 1'b0;
    int   wcnt = 0;
    int   hi = 0;
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0; DAT_I = '0;
    forever begin
      @(negedge CLK_I);
      ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0; DAT_I = $urandom;
      if (slave_reset) begin
        active = 1'b0;
        slave_reset = 1'b0;
      end
      if (active && !STB_O) begin
        active = 1'b0;
        check("stb_high_cycles", hi, (a.term == T_SIL) ? TMO : a.waits + 1);
      end
      if (STB_O && !active) begin
        if (att_q.size() == 0) begin
          check("unexpected_stb", STB_O, 0);
        end else begin
          a = att_q.pop_front();
          active = 1'b1;
          hi = 0;
          wcnt = a.waits;
          check("bus_cyc", CYC_O, 1);
          check("bus_fields", {WE_O, ADR_O, SEL_O, WE_O ? DAT_O : 32'h0},
                {a.we, a.adr, a.sel, a.we ? a.dat : 32'h0});
        end
      end
      if (active) begin
        hi++;
        if (a.term != T_SIL && wcnt == 0) begin
          case (a.term)
            T_ACK: begin
              ACK_I = 1'b1;
              if (WE_O) slave_mem[ADR_O[5:2]] = merge(slave_mem[ADR_O[5:2]], DAT_O, SEL_O);
              else      DAT_I = slave_mem[ADR_O[5:2]];
            end
            T_ERR:   ERR_I = 1'b1;
            default: RTY_I = 1'b1;
          endcase
          wcnt = -1;
        end else if (wcnt > 0) begin
          wcnt--;
        end
      end
    end
  end

  // Response monitor and bus-activity observer.
  initial begin : monitor
    rsp_t        e;
    bit          holding = 1'b0;
    logic [31:0] sd = '0;
    logic        se = 1'b0;
    int          len = 0;
    bit          prev_stb = 1'b0, prev_rv = 1'b0, prev_cyc = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge CLK_I);
      if (mon_reset) begin
        holding = 1'b0;
        prev_stb = 1'b0; prev_rv = 1'b0; prev_cyc = 1'b0;
        mon_reset = 1'b0;
      end
      if (prev_cyc && !CYC_O) cyc_falls++;
      if (STB_O && !prev_stb) check("stb_rise_with_rsp_pending", prev_rv, 0);
      if (rsp_valid) begin
        if (!holding) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp", rsp_valid, 0);
          end else begin
            e = rsp_q.pop_front();
            check("rsp_err", rsp_err, e.err);
            if (!e.err) check("rsp_dat", rsp_dat, e.dat);
          end
          holding = 1'b1; sd = rsp_dat; se = rsp_err; len = 0;
        end else begin
          check("rsp_stable", {rsp_err, rsp_dat}, {se, sd});
        end
        len++;
        if (ready_hold > 0) begin
          rsp_ready = 1'b0;
          ready_hold--;
        end else begin
          rsp_ready = rand_ready ? 1'($urandom) : 1'b1;
        end
        if (rsp_ready) begin
          holding = 1'b0;
          if (len > max_hold_len) max_hold_len = len;
        end
      end else begin
        holding = 1'b0;
        rsp_ready = rand_ready ? 1'($urandom) : 1'b0;
      end
      prev_stb = STB_O; prev_rv = rsp_valid; prev_cyc = CYC_O;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    int f0;
    int n;
    cmd_t c;
    int r;
    checks = 0; errors = 0; cyc_falls = 0; ready_hold = 0; rand_ready = 1'b0;
    max_hold_len = 0; flushing = 1'b0; slave_reset = 1'b0; mon_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = '0;
      slave_mem[i] = '0;
    end
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_last = 1'b0;

    // Reset state.
    RST_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_dat, busy, CYC_O, STB_O, WE_O, SEL_O}, 0);
    check("reset_bus_regs", {ADR_O, DAT_O}, 0);
    RST_I = 1'b0;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1);
    check("busy_after_reset", {busy, CYC_O}, 0);

    // Single write, two wait states.
    f0 = cyc_falls;
    push(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, T_ACK, 2));
    @(negedge CLK_I);
    check("no_issue_on_push_edge", STB_O, 0);
    wait_idle("single_write");
    check("single_write_cyc_falls", cyc_falls - f0, 1);

    // Fill 0x0..0xC, then a 4-beat read burst within one cycle.
    for (int i = 0; i < 4; i++)
      push(mk(1, 32'(i * 4), 32'((i + 1) * 32'h11), 4'hF, i == 3, 0, T_ACK, i % 2));
    wait_idle("write_burst");
    f0 = cyc_falls;
    for (int i = 0; i < 4; i++)
      push(mk(0, 32'(i * 4), 32'h0, 4'hF, i == 3, 0, T_ACK, i % 3));
    wait_idle("read_burst");
    check("read_burst_cyc_falls", cyc_falls - f0, 1);

    // Two retries then ACK: two back-off gaps plus the cycle end.
    f0 = cyc_falls;
    push(mk(1, 32'h20, 32'hCAFEF00D, 4'hF, 1, 2, T_ACK, 1));
    wait_idle("retry_twice");
    check("retry_twice_cyc_falls", cyc_falls - f0, 3);

    // Four retries exhaust MAX_RETRY=3, then a normal read follows.
    f0 = cyc_falls;
    push(mk(1, 32'h20, 32'h12345678, 4'hF, 1, 4, T_ACK, 0));
    push(mk(0, 32'h20, 32'h0, 4'hF, 1, 0, T_ACK, 0));
    wait_idle("retry_exhaust");
    check("retry_exhaust_cyc_falls", cyc_falls - f0, 5);

    // ERR on beat 2 of 4: beats 3-4 flushed, then a read shows they never wrote.
    f0 = cyc_falls;
    push(mk(1, 32'h24, 32'hA1A1A1A1, 4'hF, 0, 0, T_ACK, 0));
    push(mk(1, 32'h28, 32'hA2A2A2A2, 4'hF, 0, 0, T_ERR, 1));
    push(mk(1, 32'h2C, 32'hA3A3A3A3, 4'hF, 0, 0, T_ACK, 0));
    push(mk(1, 32'h0C, 32'hA4A4A4A4, 4'hF, 1, 0, T_ACK, 0));
    push(mk(0, 32'h0C, 32'h0, 4'hF, 1, 0, T_ACK, 0));
    wait_idle("err_flush");
    check("err_flush_cyc_falls", cyc_falls - f0, 2);

    // Silent slave: abort after TIMEOUT strobe cycles.
    push(mk(0, 32'h14, 32'h0, 4'hF, 1, 0, T_SIL, 0));
    wait_idle("timeout");

    // Response held 5 cycles with a second beat queued behind it.
    max_hold_len = 0;
    ready_hold = 5;
    push(mk(1, 32'h30, 32'h55AA55AA, 4'h5, 1, 0, T_ACK, 0));
    push(mk(0, 32'h30, 32'h0, 4'hF, 1, 0, T_ACK, 0));
    wait_idle("rsp_hold");
    check("rsp_hold_cycles", max_hold_len, 6);

    // Blocked response lets the FIFO fill; cmd_ready must drop at 4 entries.
    ready_hold = 20;
    for (int i = 0; i < 5; i++)
      push(mk(1, 32'(8'h30 + i * 4), $urandom, 4'hF, 1, 0, T_ACK, 0));
    check("fifo_full_ready", cmd_ready, 0);
    wait_idle("fifo_full");
    ready_hold = 0;

    // Reset in the middle of a strobe.
    push(mk(0, 32'h38, 32'h0, 4'hF, 1, 0, T_SIL, 0));
    n = 0;
    while (!STB_O && n < 50) begin
      @(negedge CLK_I);
      n++;
    end
    check("stb_before_reset", STB_O, 1);
    #2 RST_I = 1'b1;
    #1 check("reset_mid_cycle", {CYC_O, STB_O, rsp_valid, busy, cmd_ready}, 0);
    att_q.delete();
    rsp_q.delete();
    flushing = 1'b0;
    slave_reset = 1'b1;
    mon_reset = 1'b1;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);

    // Randomised traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      c.we   = 1'($urandom_range(0, 1));
      c.adr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      c.dat  = $urandom;
      c.sel  = 4'($urandom_range(1, 15));
      c.last = ($urandom_range(0, 2) == 0) || (i == 199);
      r = $urandom_range(0, 99);
      c.nrty = (r < 70) ? 0 : (r < 85) ? 1 : (r < 92) ? int'($urandom_range(2, 3)) : 4;
      r = $urandom_range(0, 99);
      c.term = (r < 85) ? T_ACK : (r < 95) ? T_ERR : T_SIL;
      c.waits = $urandom_range(0, 2);
      push(c);
    end
    wait_idle("random");
    check("final_queues_empty", {att_q.size() != 0, rsp_q.size() != 0, flushing}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
